// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock,
// start/busy/done handshake, divide-by-zero reported through div_zero.
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        ZERO
    } state_t;

    state_t           state_reg;
    logic [WIDTH:0]   p_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] dvsr_reg;
    logic [WIDTH-1:0] dvnd_reg;
    logic [CW-1:0]    cnt_reg;

    logic [WIDTH:0]   p_shift;
    logic [WIDTH:0]   p_next;
    logic [WIDTH-1:0] q_next;
    logic             fits;

    // One restoring step: shift the next dividend bit into P, subtract if it fits.
    always_comb begin
        p_shift = {p_reg[WIDTH-1:0], q_reg[WIDTH-1]};
        fits    = (p_shift >= {1'b0, dvsr_reg});
        p_next  = fits ? (p_shift - {1'b0, dvsr_reg}) : p_shift;
        q_next  = {q_reg[WIDTH-2:0], fits};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            p_reg     <= '0;
            q_reg     <= '0;
            dvsr_reg  <= '0;
            dvnd_reg  <= '0;
            cnt_reg   <= '0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // busy is low only in IDLE, so start is honoured only here
                    if (start) begin
                        dvsr_reg  <= divisor;
                        dvnd_reg  <= dividend;
                        q_reg     <= dividend;
                        p_reg     <= '0;
                        cnt_reg   <= '0;
                        busy      <= 1'b1;
                        div_zero  <= 1'b0;
                        state_reg <= (divisor == '0) ? ZERO : RUN;
                    end
                end
                RUN: begin
                    p_reg   <= p_next;
                    q_reg   <= q_next;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CW'(WIDTH - 1)) begin
                        quotient  <= q_next;
                        remainder <= p_next[WIDTH-1:0];
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                ZERO: begin
                    quotient  <= '1;
                    remainder <= dvnd_reg;
                    div_zero  <= 1'b1;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (WIDTH=4): the driver queues expected
// results with their due cycle, a monitor pops and compares on every done.
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       done;
    logic       div_zero;

    typedef struct {
        logic [3:0] q;
        logic [3:0] r;
        logic       dz;
        int         due;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    seq_divider #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .quotient (quotient),
        .remainder(remainder),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Called at a negedge: raise start with operands and queue the expected result.
    task automatic issue(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] eq, input logic [3:0] er, input logic edz);
        exp_t e;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        e.q   = eq;
        e.r   = er;
        e.dz  = edz;
        e.due = cyc + 1 + ((b == 4'd0) ? 1 : 4);
        exp_q.push_back(e);
        $display("issue %0d/%0d expect q=%0d r=%0d dz=%0d at cycle %0d", a, b, eq, er, edz, e.due);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) return;
        end
        total++;
        bad++;
        $display("FAIL done_timeout: no done within 20 cycles (cycle %0d)", cyc);
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: q=%0d r=%0d at cycle %0d", quotient, remainder, cyc);
                end else begin
                    e = exp_q.pop_front();
                    $display("done q=%0d r=%0d dz=%0d at cycle %0d", quotient, remainder, div_zero, cyc);
                    chk("quotient", quotient, e.q);
                    chk("remainder", remainder, e.r);
                    chk("div_zero", div_zero, e.dz);
                    chk("done_cycle", cyc, e.due);
                    chk("busy_at_done", busy, 0);
                end
            end
        end
    end

    initial begin
        exp_t dropped;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 4'd0;
        divisor  = 4'd0;
        repeat (2) @(negedge clk);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_div_zero", div_zero, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 13/3 with busy observed for the whole run
        issue(4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
        @(negedge clk);
        start = 1'b0;
        chk("busy_run1", busy, 1);
        @(negedge clk);
        chk("busy_run2", busy, 1);
        @(negedge clk);
        chk("busy_run3", busy, 1);
        wait_done();

        // 2/7 then 15/1 started in the done cycle
        @(negedge clk);
        issue(4'd2, 4'd7, 4'd0, 4'd2, 1'b0);
        @(negedge clk);
        start = 1'b0;
        wait_done();
        issue(4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // 9/0, div_zero held, then cleared by the next accepted start
        @(negedge clk);
        issue(4'd9, 4'd0, 4'd15, 4'd9, 1'b1);
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (2) @(negedge clk);
        chk("div_zero_hold", div_zero, 1);
        chk("quotient_hold", quotient, 15);
        issue(4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
        @(negedge clk);
        start = 1'b0;
        chk("div_zero_clear", div_zero, 0);
        chk("quotient_not_partial", quotient, 15);
        wait_done();

        // 6/4 with a second start during busy that must be ignored
        @(negedge clk);
        issue(4'd6, 4'd4, 4'd1, 4'd2, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start    = 1'b1;
        dividend = 4'd15;
        divisor  = 4'd1;
        @(negedge clk);
        start    = 1'b0;
        dividend = 4'd0;
        divisor  = 4'd0;
        wait_done();

        // 14/3 aborted by reset: no done, outputs back to zero
        @(negedge clk);
        issue(4'd14, 4'd3, 4'd4, 4'd2, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_quotient", quotient, 0);
        chk("abort_remainder", remainder, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_div_zero", div_zero, 0);
        rst_n = 1'b1;
        dropped = exp_q.pop_back();
        $display("aborted %0d/%0d entry removed", 14, 3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end
        issue(4'd14, 4'd3, 4'd4, 4'd2, 1'b0);
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // all 256 pairs, each started in the previous done cycle
        @(negedge clk);
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0)
                    issue(4'(a), 4'd0, 4'd15, 4'(a), 1'b1);
                else
                    issue(4'(a), 4'(b), 4'(a / b), 4'(a % b), 1'b0);
                @(negedge clk);
                start = 1'b0;
                wait_done();
            end
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
